// File: rtl/pc_npc_sequencer_if.sv
// pc_npc_sequencer_if: fetch-sequencer bus between decode/ALU and the PC/nPC sequencer.
//   master : drives the instruction, handshake, immediate, condition codes and JMPL target;
//            observes the PC/nPC pair and the status pulses.
//   slave  : the sequencer side (pc_npc_sequencer).
interface pc_npc_sequencer_if;
  logic [31:0] Instruction;
  logic        Instr_Valid;
  logic        Stall;
  logic [31:0] Imm;
  logic [3:0]  Icc;          // {N,Z,V,C}
  logic [31:0] Jmpl_Target;
  logic [31:0] PC;
  logic [31:0] nPC;
  logic        Annul;
  logic        Branch_Taken;
  logic        Link_We;
  logic [31:0] Link_Addr;
  logic        Misalign;

  modport master (
    output Instruction, Instr_Valid, Stall, Imm, Icc, Jmpl_Target,
    input  PC, nPC, Annul, Branch_Taken, Link_We, Link_Addr, Misalign
  );

  modport slave (
    input  Instruction, Instr_Valid, Stall, Imm, Icc, Jmpl_Target,
    output PC, nPC, Annul, Branch_Taken, Link_We, Link_Addr, Misalign
  );
endinterface

// File: rtl/pc_npc_sequencer.sv
// pc_npc_sequencer: SPARC PC/nPC sequencer with delayed-branch and annul handling.
// Ports:
//   Clk     - rising-edge clock
//   Reset_n - asynchronous active-low reset
//   bus     - pc_npc_sequencer_if.slave: Instruction/Instr_Valid/Stall/Imm/Icc/Jmpl_Target in;
//             PC/nPC/Annul/Branch_Taken/Link_We/Link_Addr/Misalign out (all registered).
// Build option: define PC_ALIGN_CHECK_EN to load CTI targets unmodified and raise a sticky
// Misalign on a target with [1:0] != 0; otherwise targets are word-aligned and Misalign is 0.
module pc_npc_sequencer (
  input  logic                    Clk,
  input  logic                    Reset_n,
  pc_npc_sequencer_if.slave       bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        annul_q, annul_d;
  logic        taken_q, taken_d;
  logic        link_we_q, link_we_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        misalign_q, misalign_d;

  logic        advance;
  logic [1:0]  op;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic        a_bit;
  logic [3:0]  cond;
  logic        icc_n, icc_z, icc_v, icc_c;
  logic        base_test;
  logic        cond_true;
  logic        is_bicc, is_call, is_jmpl;
  logic        cti_taken;
  logic [31:0] raw_target;
  logic [31:0] target;

  assign advance = bus.Instr_Valid & ~bus.Stall;

  assign op    = bus.Instruction[31:30];
  assign op2   = bus.Instruction[24:22];
  assign op3   = bus.Instruction[24:19];
  assign a_bit = bus.Instruction[29];
  assign cond  = bus.Instruction[28:25];

  assign icc_n = bus.Icc[3];
  assign icc_z = bus.Icc[2];
  assign icc_v = bus.Icc[1];
  assign icc_c = bus.Icc[0];

  always_comb begin
    base_test = 1'b0;
    unique case (cond[2:0])
      3'b000: base_test = 1'b0;
      3'b001: base_test = icc_z;
      3'b010: base_test = icc_z | (icc_n ^ icc_v);
      3'b011: base_test = icc_n ^ icc_v;
      3'b100: base_test = icc_c | icc_z;
      3'b101: base_test = icc_c;
      3'b110: base_test = icc_n;
      3'b111: base_test = icc_v;
      default: base_test = 1'b0;
    endcase
  end

  assign cond_true = base_test ^ cond[3];

  // A squashed delay slot is never decoded as a CTI.
  assign is_bicc = ~annul_q & (op == 2'b00) & (op2 == 3'b010);
  assign is_call = ~annul_q & (op == 2'b01);
  assign is_jmpl = ~annul_q & (op == 2'b10) & (op3 == 6'b111000);

  assign cti_taken  = is_call | is_jmpl | (is_bicc & cond_true);
  assign raw_target = is_jmpl ? bus.Jmpl_Target : (pc_q + bus.Imm);

`ifdef PC_ALIGN_CHECK_EN
  assign target = raw_target;
`else
  assign target = {raw_target[31:2], 2'b00};
`endif

  always_comb begin
    pc_d        = pc_q;
    npc_d       = npc_q;
    annul_d     = annul_q;
    taken_d     = 1'b0;
    link_we_d   = 1'b0;
    link_addr_d = link_addr_q;
    misalign_d  = misalign_q;
    if (advance) begin
      pc_d    = npc_q;
      npc_d   = cti_taken ? target : (npc_q + 32'd4);
      // BA,a annuls its slot even though it is taken.
      annul_d = is_bicc & a_bit & (~cond_true | (cond == 4'b1000));
      taken_d = cti_taken;
      if (is_call | is_jmpl) begin
        link_we_d   = 1'b1;
        link_addr_d = pc_q;
      end
`ifdef PC_ALIGN_CHECK_EN
      if (cti_taken && (raw_target[1:0] != 2'b00)) begin
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q        <= 32'h0000_0000;
      npc_q       <= 32'h0000_0004;
      annul_q     <= 1'b0;
      taken_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_addr_q <= 32'h0000_0000;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      annul_q     <= annul_d;
      taken_q     <= taken_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.nPC          = npc_q;
  assign bus.Annul        = annul_q;
  assign bus.Branch_Taken = taken_q;
  assign bus.Link_We      = link_we_q;
  assign bus.Link_Addr    = link_addr_q;
  assign bus.Misalign     = misalign_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// tb_pc_npc_sequencer: directed-vector bench for pc_npc_sequencer.
module tb_pc_npc_sequencer;

  localparam logic [31:0] NOP   = 32'h0100_0000;  // sethi 0,%g0
  localparam logic [31:0] BE    = 32'h0280_0000;  // cond=0001 a=0
  localparam logic [31:0] BNE_A = 32'h3280_0000;  // cond=1001 a=1
  localparam logic [31:0] BA_A  = 32'h3080_0000;  // cond=1000 a=1
  localparam logic [31:0] CALL  = 32'h4000_0000;
  localparam logic [31:0] JMPL  = 32'h81C0_0000;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;

  pc_npc_sequencer_if bus ();

  pc_npc_sequencer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction, clock it in, and sample 1 time unit after the edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] imm, input logic [3:0] icc,
                      input logic [31:0] jt);
    bus.Instruction = instr;
    bus.Imm         = imm;
    bus.Icc         = icc;
    bus.Jmpl_Target = jt;
    bus.Instr_Valid = 1'b1;
    @(posedge Clk);
    #1;
    bus.Instr_Valid = 1'b0;
  endtask

  logic [31:0] exp_npc_j;
  logic        exp_mis;

  initial begin
    checks          = 0;
    errors          = 0;
    Reset_n         = 1'b0;
    bus.Instruction = NOP;
    bus.Instr_Valid = 1'b0;
    bus.Stall       = 1'b0;
    bus.Imm         = 32'h0;
    bus.Icc         = 4'h0;
    bus.Jmpl_Target = 32'h0;

    #12;
    check_eq("reset_pc", bus.PC, 32'h0);
    check_eq("reset_npc", bus.nPC, 32'h4);
    check_eq("reset_annul", {31'h0, bus.Annul}, 32'h0);
    check_eq("reset_link_addr", bus.Link_Addr, 32'h0);
    check_eq("reset_misalign", {31'h0, bus.Misalign}, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;

    // Three sequential ALU ops.
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("seq1_pc", bus.PC, 32'h4);
    check_eq("seq1_npc", bus.nPC, 32'h8);
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("seq2_pc", bus.PC, 32'h8);
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("seq3_pc", bus.PC, 32'hC);
    check_eq("seq3_npc", bus.nPC, 32'h10);
    check_eq("seq3_link_we", {31'h0, bus.Link_We}, 32'h0);
    check_eq("seq3_taken", {31'h0, bus.Branch_Taken}, 32'h0);

    // Fetch bubble: nothing moves.
    @(posedge Clk);
    #1;
    check_eq("bubble_pc", bus.PC, 32'hC);
    check_eq("bubble_npc", bus.nPC, 32'h10);

    // Jump to 0x100 (JMPL at 0xC, slot at 0x10).
    step(JMPL, 32'h0, 4'h0, 32'h100);
    check_eq("j100_npc", bus.nPC, 32'h100);
    check_eq("j100_link_we", {31'h0, bus.Link_We}, 32'h1);
    check_eq("j100_link_addr", bus.Link_Addr, 32'hC);
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("j100_slot_pc", bus.PC, 32'h100);
    check_eq("j100_link_we_drop", {31'h0, bus.Link_We}, 32'h0);

    // BE taken with Z=1.
    step(BE, 32'h40, 4'b0100, 32'h0);
    check_eq("be_taken", {31'h0, bus.Branch_Taken}, 32'h1);
    check_eq("be_npc", bus.nPC, 32'h140);
    check_eq("be_pc_slot", bus.PC, 32'h104);
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("be_after_pc", bus.PC, 32'h140);
    check_eq("be_taken_drop", {31'h0, bus.Branch_Taken}, 32'h0);

    // Jump to 0x200, then BNE,a untaken with Z=1.
    step(JMPL, 32'h0, 4'h0, 32'h200);
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("j200_pc", bus.PC, 32'h200);
    step(BNE_A, 32'h80, 4'b0100, 32'h0);
    check_eq("bne_pc", bus.PC, 32'h204);
    check_eq("bne_annul", {31'h0, bus.Annul}, 32'h1);
    check_eq("bne_taken", {31'h0, bus.Branch_Taken}, 32'h0);
    check_eq("bne_npc", bus.nPC, 32'h208);
    // The annulled slot holds a CALL; it must not be treated as one.
    step(CALL, 32'h1000, 4'h0, 32'h0);
    check_eq("annslot_pc", bus.PC, 32'h208);
    check_eq("annslot_annul", {31'h0, bus.Annul}, 32'h0);
    check_eq("annslot_link_we", {31'h0, bus.Link_We}, 32'h0);
    check_eq("annslot_npc", bus.nPC, 32'h20C);

    // Jump to 0x300, then CALL backwards.
    step(JMPL, 32'h0, 4'h0, 32'h300);
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("j300_pc", bus.PC, 32'h300);
    step(CALL, 32'hFFFF_FF00, 4'h0, 32'h0);
    check_eq("call_link_we", {31'h0, bus.Link_We}, 32'h1);
    check_eq("call_link_addr", bus.Link_Addr, 32'h300);
    check_eq("call_pc", bus.PC, 32'h304);
    check_eq("call_npc", bus.nPC, 32'h200);
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("call_after_pc", bus.PC, 32'h200);

    // JMPL to a misaligned target.
`ifdef PC_ALIGN_CHECK_EN
    exp_npc_j = 32'h1002;
    exp_mis   = 1'b1;
`else
    exp_npc_j = 32'h1000;
    exp_mis   = 1'b0;
`endif
    step(JMPL, 32'h0, 4'h0, 32'h1002);
    check_eq("jmis_npc", bus.nPC, exp_npc_j);
    check_eq("jmis_misalign", {31'h0, bus.Misalign}, {31'h0, exp_mis});
    check_eq("jmis_link_addr", bus.Link_Addr, 32'h200);
    step(NOP, 32'h0, 4'h0, 32'h0);
    check_eq("jmis_slot_pc", bus.PC, exp_npc_j);

    // BA,a then stall on the annulled slot.
    step(BA_A, 32'h40, 4'h0, 32'h0);
    check_eq("baa_annul", {31'h0, bus.Annul}, 32'h1);
    check_eq("baa_taken", {31'h0, bus.Branch_Taken}, 32'h1);
    check_eq("baa_pc", bus.PC, exp_npc_j + 32'd4);
    bus.Stall       = 1'b1;
    bus.Instr_Valid = 1'b1;
    bus.Instruction = NOP;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      check_eq("stall_annul", {31'h0, bus.Annul}, 32'h1);
      check_eq("stall_pc", bus.PC, exp_npc_j + 32'd4);
      check_eq("stall_taken", {31'h0, bus.Branch_Taken}, 32'h0);
    end
    check_eq("stall_misalign", {31'h0, bus.Misalign}, {31'h0, exp_mis});

    // Asynchronous reset mid-hold, away from a clock edge.
    #2;
    Reset_n = 1'b0;
    #1;
    check_eq("areset_pc", bus.PC, 32'h0);
    check_eq("areset_npc", bus.nPC, 32'h4);
    check_eq("areset_annul", {31'h0, bus.Annul}, 32'h0);
    check_eq("areset_misalign", {31'h0, bus.Misalign}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_npc_sequencer.md
# pc_npc_sequencer

Sequences the SPARC PC/nPC pair for the fetch stage. On each advancing instruction it evaluates Bicc conditions against the integer condition codes and selects the next nPC: sequential, PC-relative branch/CALL target, or JMPL register target. It applies delayed-branch semantics, including the annul bit, and flags the squashed delay slot to the datapath. It sits between the decode-stage immediate generator, which supplies 4*disp22 / 4*disp30, and the instruction memory address port.

## Interface
- No parameters; all widths fixed at 32 bits.
- Clk  in  1  rising-edge clock, the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Instruction  in  32  instruction currently at PC.
- Instr_Valid  in  1  Instruction is valid this cycle.
- Stall  in  1  pipeline hold; inhibits advance.
- Imm  in  32  sign-extended, shifted displacement from the immediate generator (4*disp22 for Bicc, 4*disp30 for CALL).
- Icc  in  4  {N,Z,V,C}.
- Jmpl_Target  in  32  rs1+operand2 from the ALU, valid with a JMPL instruction.
- PC  out  32  address of the current instruction.
- nPC  out  32  address of the next instruction.
- Annul  out  1  current instruction is a squashed delay slot; the datapath must not commit it.
- Branch_Taken  out  1  one-cycle pulse after a taken CTI advances.
- Link_We  out  1  one-cycle pulse after a CALL/JMPL advances.
- Link_Addr  out  32  PC of that CALL/JMPL, which is written to r15 or rd.
- Misalign  out  1  sticky target-misalignment flag (see Configuration).

## Operation
- Advance = Instr_Valid & ~Stall. With no advance, all state holds and the pulses deassert.
- Decode uses op = Instruction[31:30], op2 = [24:22], op3 = [24:19], a = [29], cond = [28:25].
- Bicc (op=00, op2=010):
  - cond[2:0] selects the base test: 000 false, 001 Z, 010 Z|(N^V), 011 N^V, 100 C|Z, 101 C, 110 N, 111 V.
  - cond[3] inverts the base test, so 1000 means always.
  - Taken: nPC' = PC + Imm. Not taken: nPC' = nPC + 4.
- CALL (op=01): nPC' = PC + Imm. Link_Addr' = PC.
- JMPL (op=10, op3=111000): nPC' = Jmpl_Target. Link_Addr' = PC.
- Everything else, including SETHI, ALU, memory, and any instruction advanced while Annul=1: nPC' = nPC + 4.
- On every advance, PC' = nPC. This is the delayed-branch behaviour; the delay slot always follows the CTI.
- Annul' = 1 when a Bicc has a=1 and is either untaken or cond=1000. Otherwise Annul' = 0.
- When Annul=1, the instruction is not decoded as a CTI. Its advance clears Annul.
- Arithmetic is modulo 2^32; wrap-around from 0xFFFFFFFC to 0 is legal.
- Reset values: PC=0x00000000, nPC=0x00000004, Annul=0, Branch_Taken=0, Link_We=0, Link_Addr=0, Misalign=0.

## Timing
- All outputs are registered. A decision made on an advancing edge is visible on the outputs the next cycle, giving 1-cycle latency.
- Branch_Taken and Link_We are high for exactly one cycle after the advancing edge, even if Stall rises in that cycle.
- With Stall=1, PC, nPC and Annul hold indefinitely. An annulled slot stays flagged until it actually advances.
- When Instr_Valid=0 and Stall=0, nothing advances. Fetch bubbles do not consume the delay slot.
- A CTI in a delay slot (not annulled) follows SPARC DCTI order: PC takes the first target and nPC takes the second.
- Reset_n low forces the reset values immediately, independent of Clk. The first advance may occur on the first rising edge after Reset_n is released.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Misalign sets on the advance of a CALL, JMPL, or taken Bicc whose computed target has [1:0] != 00.
  - Misalign stays set until reset.
  - The target is loaded unmodified.
- PC_ALIGN_CHECK_EN undefined:
  - Misalign is tied to 0.
  - Target bits [1:0] are forced to 00 before loading nPC.

## Test plan
- Reset, then advance 3 plain ALU ops -> PC 0→4→8→C and nPC 4→8→C→10. Link_We and Branch_Taken stay 0.
- At PC=0x100, BE (cond=0001, a=0) with Imm=0x40 and Z=1, then a delay slot -> Branch_Taken pulse; after the slot, PC=0x140.
- At PC=0x200, BNE (cond=1001, a=1) with Z=1 -> untaken; the instruction at 0x204 is presented with Annul=1, then PC=0x208 with Annul=0.
- At PC=0x300, CALL with Imm=0xFFFFFF00 -> Link_We pulse with Link_Addr=0x300; the delay slot is at 0x304, then PC=0x200.
- JMPL with Jmpl_Target=0x1002 -> with the macro, Misalign=1 and nPC=0x1002; without it, Misalign=0 and nPC=0x1000.
- BA,a with Stall held for 5 cycles on the annulled slot, then Reset_n pulsed low mid-hold -> Annul holds at 1 throughout the stall; on reset, PC=0, nPC=4 and Annul=0 immediately.
